add_n_sgn_pipe: RTL and testbench
=================================

# add_n_sgn_pipe

Pipelined, parametrised signed multi-operand adder and subtractor for the datapath benchmark set. It sums N signed BW-bit operands in one beat, and a per-operand subtract mask selects add or subtract for each operand. The sum is reduced through a carry-save tree split over STAGES register stages, under a valid/ready handshake. It replaces fixed three-operand combinational adders wherever operand count, throughput or timing closure matter.

## Interface
- BW, 8: operand width, signed, ≥2
- N, 3: operand count, ≥2
- STAGES, 2: register stages from input to output, 1..4
- OW, BW+$clog2(N)+1: result width, ≤ FW where FW = BW+$clog2(N)+1
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_ops  in  N*BW  operands packed; operand i at [i*BW +: BW], signed
- in_sub  in  N  bit i=1 subtracts operand i
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  OW  signed result
- out_sat  out  1  result was clamped (SAT_EN only, else 0)

## Operation
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Exact result R = Σ (in_sub[i] ? −op_i : op_i), computed at FW bits. FW never overflows, including the case −(−2^(BW−1)).
- Negation is ~op_i plus a +1 correction. All +1 corrections are summed into a single constant vector and injected into the tree; no separate carry chains.
- The reduction is a Wallace/Dadda-style tree of 3:2 compressors down to two rows, followed by one final carry-propagate adder in the last stage.
- Compressor levels are distributed as evenly as possible over STAGES. The CPA always sits in the last stage.
- Pipeline uses a global stall: in_ready = !out_valid || out_ready. When in_ready=0, all stage registers and valids hold.
- Each stage holds a valid bit. Bubbles propagate while the output is not stalled; there is no bubble-collapse.
- Output width when OW < FW: see Configuration. When OW = FW, out_sum = R exactly.

## Timing
- Reset (async assert, sync deassert externally): all stage valids = 0, out_valid=0, out_sum=0, out_sat=0, in_ready=1.
- Latency: a beat accepted at edge t appears on out_valid after edge t+STAGES−1 when unstalled. STAGES=1 means the registered output is visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0 in the same cycle (combinational). out_sum/out_sat hold stable until the transfer.
- Simultaneous: if out_ready=1 and in_valid=1 while full, the output transfers and a new beat is accepted on the same edge; no beat is lost.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- in_ops and in_sub are sampled only on acceptance.

## Configuration
- ADD_N_SGN_SAT_EN defined: out_sum = R clamped to [−2^(OW−1), 2^(OW−1)−1]. out_sat=1 exactly when clamping occurred. The compare logic is in the last stage.
- Not defined: out_sum = R[OW−1:0] (two's-complement wrap) and out_sat is tied 0.
- With OW = FW, both builds give identical out_sum, and out_sat is always 0.

## Structure
- Package add_n_sgn_pkg holds:
  - function fw(bw, n)
  - function levels(n): number of 3:2 levels needed to reach 2 rows
  - function stage_of_level(level, levels, stages)
  - localparam-style helpers for packed-operand slicing
- One sub-module, csa_3to2, is parametrised by width. It takes three rows and produces sum and carry<<1 rows, and is instantiated by generate loops per level.
- The top level contains the row arrays, stage registers with valid/stall, the final CPA and the optional saturation.

## Test plan
- BW=8,N=3,STAGES=2: ops {−128,−128,−128}, sub=000 → out_sum=−384 (FW=11), out_valid 2 cycles after acceptance, out_sat=0.
- Same config, ops {−128,5,7}, sub=001 → out_sum=140 (the −(−128) case).
- SAT_EN, OW=8: ops {100,100,0}, sub=000 → out_sum=127, out_sat=1; without the macro → out_sum=−56, out_sat=0.
- Back-to-back 20 random beats with out_ready toggling 1,0,0,1… → every result matches the model in order; in_ready low exactly when out_valid&&!out_ready; held output is stable.
- Assert rst with 2 beats in flight → out_valid=0 the same cycle, in_ready=1; no stale result after release.
- N=8, BW=16, STAGES=4, all ops −32768, sub=0xFF → out_sum=262144, latency 4, full throughput.

Source files
------------

// File: rtl/add_n_sgn_pkg.sv
// Elaboration-time helpers for add_n_sgn_pipe: widths, 3:2 tree shape and stage mapping.
package add_n_sgn_pkg;

  function automatic int unsigned fw(int unsigned bw, int unsigned n);
    return bw + $clog2(n) + 1;
  endfunction

  // Row count left after lvl levels of 3:2 compression starting from rows.
  function automatic int unsigned rows_after(int unsigned rows, int unsigned lvl);
    int unsigned r;
    r = rows;
    for (int unsigned k = 0; k < lvl; k++) begin
      if (r > 2) r = 2 * (r / 3) + r % 3;
    end
    return r;
  endfunction

  function automatic int unsigned levels(int unsigned n);
    int unsigned r;
    int unsigned cnt;
    r   = n;
    cnt = 0;
    while (r > 2) begin
      r   = 2 * (r / 3) + r % 3;
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  function automatic int unsigned stage_of_level(int unsigned level, int unsigned n_lvl,
                                                 int unsigned stages);
    return (level * stages) / n_lvl;
  endfunction

  function automatic int unsigned op_lo(int unsigned i, int unsigned bw);
    return i * bw;
  endfunction

endpackage

// File: rtl/add_n_sgn_pipe_if.sv
// Beat-in / result-out handshake bundle for add_n_sgn_pipe.
interface add_n_sgn_pipe_if #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 3,
  parameter int unsigned OW = BW + $clog2(N) + 1
);
  logic          in_valid;
  logic          in_ready;
  logic [N*BW-1:0] in_ops;
  logic [N-1:0]  in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic          out_sat;

  modport master (
    output in_valid, in_ops, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_ops, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor row: three rows in, sum row and left-shifted carry row out.
module csa_3to2 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);
  logic [W-1:0] maj;
  logic         unused_maj_msb;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  // Modular arithmetic at full width: the carry out of the top bit is discarded.
  assign carry_o = {maj[W-2:0], 1'b0};
  assign unused_maj_msb = maj[W-1];
endmodule

// File: rtl/add_n_sgn_pipe.sv
// Pipelined signed N-operand add/subtract: 3:2 tree spread over STAGES registers, CPA last.
// Define ADD_N_SGN_SAT_EN to clamp out_sum to OW bits (out_sat flags it) instead of wrapping.
module add_n_sgn_pipe
  import add_n_sgn_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned N      = 3,
  parameter int unsigned STAGES = 2,
  parameter int unsigned OW     = fw(BW, N)
) (
  input logic             clk,
  input logic             rst,
  add_n_sgn_pipe_if.slave bus
);
  localparam int unsigned FW = fw(BW, N);
  localparam int unsigned M  = N + 1;  // operands plus one row of +1 corrections
  localparam int unsigned LV = levels(M);

  logic [FW-1:0]     prep   [M];
  logic [FW-1:0]     row_v  [STAGES][LV+1][M];
  logic [FW-1:0]     rows_q [STAGES][M];
  logic [FW-1:0]     rows_d [STAGES][M];
  logic [STAGES-1:0] vld_q, vld_d, vin;
  logic [OW-1:0]     sum_q, sum_d, sum_c;
  logic              sat_q, sat_d, sat_c;
  logic [FW-1:0]     cpa;
  logic              in_ready;
  logic              unused_cpa;

  always_comb begin
    logic [BW-1:0] op;
    logic [FW-1:0] ext;
    logic [FW-1:0] corr;
    op   = '0;
    ext  = '0;
    corr = '0;
    prep = '{default: '0};
    for (int unsigned i = 0; i < N; i++) begin
      op      = bus.in_ops[op_lo(i, BW) +: BW];
      ext     = {{(FW - BW){op[BW-1]}}, op};
      prep[i] = bus.in_sub[i] ? ~ext : ext;
      corr    = corr + FW'(bus.in_sub[i]);
    end
    prep[N] = corr;
  end

  // row_v[s][l] is the row set entering level l inside stage s; levels owned by
  // another stage pass through untouched.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar r = 0; r < M; r++) begin : g_in
      if (s == 0) begin : g_first
        assign row_v[s][0][r] = prep[r];
      end else begin : g_reg
        assign row_v[s][0][r] = rows_q[s-1][r];
      end
    end
    if (s == 0) begin : g_vin0
      assign vin[s] = bus.in_valid;
    end else begin : g_vinn
      assign vin[s] = vld_q[s-1];
    end
    for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int unsigned RC = rows_after(M, l);
      localparam int unsigned NC = RC / 3;
      if (stage_of_level(l, LV, STAGES) == s) begin : g_csa
        for (genvar j = 0; j < NC; j++) begin : g_c
          csa_3to2 #(.W(FW)) u_csa (
            .a_i     (row_v[s][l][3*j]),
            .b_i     (row_v[s][l][3*j+1]),
            .c_i     (row_v[s][l][3*j+2]),
            .sum_o   (row_v[s][l+1][2*j]),
            .carry_o (row_v[s][l+1][2*j+1])
          );
        end
        for (genvar r = 3 * NC; r < RC; r++) begin : g_pass
          assign row_v[s][l+1][r-NC] = row_v[s][l][r];
        end
        for (genvar r = RC - NC; r < M; r++) begin : g_zero
          assign row_v[s][l+1][r] = '0;
        end
      end else begin : g_thru
        for (genvar r = 0; r < M; r++) begin : g_t
          assign row_v[s][l+1][r] = row_v[s][l][r];
        end
      end
    end
  end

  assign cpa        = row_v[STAGES-1][LV][0] + row_v[STAGES-1][LV][1];
  assign unused_cpa = ^cpa;

  always_comb begin
    sum_c = cpa[OW-1:0];
    sat_c = 1'b0;
`ifdef ADD_N_SGN_SAT_EN
    // Out of range when the bits above the OW-bit sign are not all sign copies.
    if (!(&cpa[FW-1:OW-1] || ~|cpa[FW-1:OW-1])) begin
      sum_c = {cpa[FW-1], {(OW - 1){~cpa[FW-1]}}};
      sat_c = 1'b1;
    end
`endif
  end

  assign in_ready = !vld_q[STAGES-1] || bus.out_ready;

  always_comb begin
    vld_d  = vld_q;
    rows_d = rows_q;
    sum_d  = sum_q;
    sat_d  = sat_q;
    if (in_ready) begin
      vld_d = vin;
      for (int s = 0; s < int'(STAGES) - 1; s++) begin
        if (vin[s]) rows_d[s] = row_v[s][LV];
      end
      if (vin[STAGES-1]) begin
        sum_d = sum_c;
        sat_d = sat_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      rows_q <= '{default: '0};
      sum_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      rows_q <= rows_d;
      sum_q  <= sum_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_add_n_sgn_pipe.sv
// Directed + random bench for add_n_sgn_pipe on three configurations against an integer model.
module tb_add_n_sgn_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  add_n_sgn_pipe_if #(.BW(8),  .N(3), .OW(11)) a_if ();
  add_n_sgn_pipe_if #(.BW(8),  .N(3), .OW(8))  b_if ();
  add_n_sgn_pipe_if #(.BW(16), .N(8), .OW(20)) c_if ();

  add_n_sgn_pipe #(.BW(8), .N(3), .STAGES(2), .OW(11)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  add_n_sgn_pipe #(.BW(8), .N(3), .STAGES(1), .OW(8))  u_b (.clk(clk), .rst(rst), .bus(b_if));
  add_n_sgn_pipe #(.BW(16), .N(8), .STAGES(4), .OW(20)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  int       bv [3][3] = '{'{100, 100, 0}, '{-128, -128, 0}, '{-5, 3, 1}};
  bit [2:0] bs [3]    = '{3'b000, 3'b000, 3'b010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rsum(input int ops [8], input bit [7:0] sub, input int n);
    int r;
    r = 0;
    for (int i = 0; i < n; i++) r += sub[i] ? -ops[i] : ops[i];
    return r;
  endfunction

  // Reference for the 8-bit output configuration, wrap or clamp by build.
  task automatic fit8(input int r, output int s, output int sat);
`ifdef ADD_N_SGN_SAT_EN
    if (r > 127) begin
      s = 127; sat = 1;
    end else if (r < -128) begin
      s = -128; sat = 1;
    end else begin
      s = r; sat = 0;
    end
    s = s & 'hFF;
`else
    s = r & 'hFF;
    sat = 0;
`endif
  endtask

  task automatic a_one(input string tag, input int o0, input int o1, input int o2,
                       input bit [2:0] sub);
    int ops [8];
    int r;
    ops = '{default: 0};
    ops[0] = o0; ops[1] = o1; ops[2] = o2;
    r = rsum(ops, 8'(sub), 3);
    @(negedge clk);
    a_if.in_ops    = {8'(o2), 8'(o1), 8'(o0)};
    a_if.in_sub    = sub;
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(a_if.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(a_if.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(a_if.out_sum), 32'(r & 'h7FF));
    chk({tag, "_sat"}, 32'(a_if.out_sat), 32'd0);
  endtask

  initial begin
    int q [$];
    int ops [8];
    int r, s, sat, sent, cyc;

    a_if.in_valid = 0; a_if.in_ops = '0; a_if.in_sub = '0; a_if.out_ready = 1;
    b_if.in_valid = 0; b_if.in_ops = '0; b_if.in_sub = '0; b_if.out_ready = 1;
    c_if.in_valid = 0; c_if.in_ops = '0; c_if.in_sub = '0; c_if.out_ready = 1;
    ops = '{default: 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_vld", 32'(a_if.out_valid), 32'd0);
    chk("rst_rdy", 32'(a_if.in_ready), 32'd1);
    chk("rst_sum", 32'(a_if.out_sum), 32'd0);
    chk("rst_sat", 32'(a_if.out_sat), 32'd0);
    chk("rst_b_vld", 32'(b_if.out_valid), 32'd0);

    a_one("neg3", -128, -128, -128, 3'b000);
    a_one("negneg", -128, 5, 7, 3'b001);
    a_one("mixed", 127, -1, 50, 3'b110);

    // Random back-to-back beats with out_ready pattern 1,0,0,1.
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || q.size() > 0) && cyc < 300) begin
      @(negedge clk);
      a_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 20) begin
        for (int i = 0; i < 3; i++) ops[i] = int'($urandom_range(255, 0)) - 128;
        a_if.in_ops   = {8'(ops[2]), 8'(ops[1]), 8'(ops[0])};
        a_if.in_sub   = 3'($urandom_range(7, 0));
        a_if.in_valid = 1'b1;
      end else begin
        a_if.in_valid = 1'b0;
      end
      #1;
      chk("rnd_rdy", 32'(a_if.in_ready), 32'(!(a_if.out_valid && !a_if.out_ready)));
      if (a_if.out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 32'(a_if.out_valid), 32'd0);
        end else begin
          chk("rnd_sum", 32'(a_if.out_sum), 32'(q[0] & 'h7FF));
          if (a_if.out_ready) void'(q.pop_front());
        end
      end
      if (a_if.in_valid && a_if.in_ready) begin
        q.push_back(rsum(ops, {5'b0, a_if.in_sub}, 3));
        sent++;
      end
      cyc++;
    end
    chk("rnd_drain", 32'(q.size()), 32'd0);
    chk("rnd_sent", 32'(sent), 32'd20);

    // Reset with two beats in flight.
    @(negedge clk);
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    a_if.in_ops    = {8'(33), 8'(-7), 8'(90)};
    a_if.in_sub    = 3'b010;
    @(negedge clk);
    a_if.in_ops    = {8'(1), 8'(2), 8'(3)};
    @(negedge clk);
    a_if.in_valid = 1'b0;
    chk("rst_pre_vld", 32'(a_if.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_vld", 32'(a_if.out_valid), 32'd0);
    chk("rst_mid_rdy", 32'(a_if.in_ready), 32'd1);
    chk("rst_mid_sum", 32'(a_if.out_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_stale", 32'(a_if.out_valid), 32'd0);
    end

    // STAGES=1, OW=8: wrap (or clamp) and one-edge latency.
    for (int k = 0; k < 3; k++) begin
      ops = '{default: 0};
      for (int i = 0; i < 3; i++) ops[i] = bv[k][i];
      r = rsum(ops, {5'b0, bs[k]}, 3);
      fit8(r, s, sat);
      @(negedge clk);
      b_if.in_ops   = {8'(ops[2]), 8'(ops[1]), 8'(ops[0])};
      b_if.in_sub   = bs[k];
      b_if.in_valid = 1'b1;
      @(negedge clk);
      b_if.in_valid = 1'b0;
      chk("b_vld", 32'(b_if.out_valid), 32'd1);
      chk("b_sum", 32'(b_if.out_sum), 32'(s));
      chk("b_sat", 32'(b_if.out_sat), 32'(sat));
    end

    // N=8, BW=16, STAGES=4: latency 4 and full throughput.
    q.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k > 0) chk("c_vld", 32'(c_if.out_valid), 32'(k >= 4 && k <= 9));
      if (c_if.out_valid && q.size() > 0) begin
        chk("c_sum", 32'(c_if.out_sum), 32'(q.pop_front() & 'hFFFFF));
      end
      if (k < 6) begin
        for (int i = 0; i < 8; i++)
          ops[i] = (k == 0) ? -32768 : int'($urandom_range(65535, 0)) - 32768;
        for (int i = 0; i < 8; i++) c_if.in_ops[i*16 +: 16] = 16'(ops[i]);
        c_if.in_sub   = (k == 0) ? 8'hFF : 8'($urandom_range(255, 0));
        c_if.in_valid = 1'b1;
        chk("c_rdy", 32'(c_if.in_ready), 32'd1);
        q.push_back(rsum(ops, c_if.in_sub, 8));
      end else begin
        c_if.in_valid = 1'b0;
      end
    end
    chk("c_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
